// File: rtl/seq_divider_8by4_if.sv
// seq_divider_8by4_if: request/result bundle for the sequential 8-by-4 divider.
//   master : issuing logic   (drives start/dividend/divisor, sees results)
//   slave  : divider         (samples request, drives busy/done/results)
//   start, dividend[DIVIDEND_W], divisor[DIVISOR_W]  -> divider
//   busy, done, quotient[DIVIDEND_W], remainder[DIVISOR_W] <- divider
//   div_by_zero <- divider, only when DIV_ZERO_FLAG_EN is defined
interface seq_divider_8by4_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic                  div_by_zero;

  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  busy, done, quotient, remainder);
  modport slave  (input  start, dividend, divisor,
                  output busy, done, quotient, remainder);
`endif
endinterface

// File: rtl/seq_divider_8by4.sv
// seq_divider_8by4: multi-cycle restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts any operation in flight
//   bus   : seq_divider_8by4_if.slave (start/operands in; busy/done/results out)
// A request is taken while idle; done pulses DIVIDEND_W edges after accept,
// or 1 edge after accept when divisor==0 (quotient all ones, remainder =
// low dividend bits). Results hold between completions.
// Optional: define DIV_ZERO_FLAG_EN to add bus.div_by_zero, set on each
// completion to 1 for a divide-by-zero and 0 otherwise.
module seq_divider_8by4 #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_8by4_if.slave   bus
);
  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] ZERO = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB,
  // so after DIVIDEND_W iterations this register holds the quotient.
  logic [DIVIDEND_W-1:0] dq;
  logic [DIVISOR_W-1:0]  dvs;
  logic [DIVISOR_W:0]    prem;

  // One extra bit above the partial remainder acts as the trial sign.
  logic [DIVISOR_W+1:0]  shifted, trial;
  logic                  ge;
  logic [DIVISOR_W:0]    prem_nxt;
  logic [DIVIDEND_W-1:0] dq_nxt;

  always_comb begin
    shifted  = {prem, dq[DIVIDEND_W-1]};
    trial    = shifted - {2'b00, dvs};
    ge       = ~trial[DIVISOR_W+1];
    prem_nxt = ge ? trial[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    dq_nxt   = {dq[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      dq            <= '0;
      dvs           <= '0;
      prem          <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
`ifdef DIV_ZERO_FLAG_EN
      bus.div_by_zero <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          dq       <= bus.dividend;
          dvs      <= bus.divisor;
          prem     <= '0;
          cnt      <= '0;
          bus.busy <= 1'b1;
          state    <= (bus.divisor == '0) ? ZERO : CALC;
        end
        CALC: begin
          dq   <= dq_nxt;
          prem <= prem_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            bus.quotient  <= dq_nxt;
            bus.remainder <= prem_nxt[DIVISOR_W-1:0];
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
`ifdef DIV_ZERO_FLAG_EN
            bus.div_by_zero <= 1'b0;
`endif
          end
        end
        ZERO: begin
          bus.quotient  <= '1;
          bus.remainder <= dq[DIVISOR_W-1:0];
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
`ifdef DIV_ZERO_FLAG_EN
          bus.div_by_zero <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_8by4.sv
module tb_seq_divider_8by4;
  typedef struct {
    int q;
    int r;
    int dz;
    int lat;
    int acc;
    int dvd;
    int dvs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_q = 0;
  int   last_r = 0;
  exp_t sb[$];

  seq_divider_8by4_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) dif ();

  seq_divider_8by4 #(.DIVIDEND_W(8), .DIVISOR_W(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && dif.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("q %0d/%0d", e.dvd, e.dvs), int'(dif.quotient), e.q);
        chk($sformatf("r %0d/%0d", e.dvd, e.dvs), int'(dif.remainder), e.r);
        chk($sformatf("lat %0d/%0d", e.dvd, e.dvs), cyc - e.acc, e.lat);
        chk("busy_at_done", int'(dif.busy), 0);
`ifdef DIV_ZERO_FLAG_EN
        chk($sformatf("dz %0d/%0d", e.dvd, e.dvs), int'(dif.div_by_zero), e.dz);
`endif
      end
      last_q = int'(dif.quotient);
      last_r = int'(dif.remainder);
    end else if (rst_n && dif.busy) begin
      if (int'(dif.quotient) != last_q || int'(dif.remainder) != last_r)
        chk("hold_while_busy", int'(dif.quotient) * 16 + int'(dif.remainder),
            last_q * 16 + last_r);
    end
  end

  function automatic exp_t model(input int dvd, input int dvs);
    exp_t e;
    e.dvd = dvd; e.dvs = dvs; e.acc = 0;
    if (dvs == 0) begin
      e.q = 255; e.r = dvd % 16; e.dz = 1; e.lat = 1;
    end else begin
      e.q = dvd / dvs; e.r = dvd % dvs; e.dz = 0; e.lat = 8;
    end
    return e;
  endfunction

  // Called at a negedge: waits (bounded) until the divider is idle.
  task automatic wait_idle();
    int n = 0;
    while (dif.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (dif.busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_op(input int dvd, input int dvs);
    exp_t e;
    @(negedge clk);
    wait_idle();
    dif.start    = 1'b1;
    dif.dividend = 8'(dvd);
    dif.divisor  = 4'(dvs);
    @(posedge clk);
    #1;
    e = model(dvd, dvs);
    e.acc = cyc;
    sb.push_back(e);
    dif.start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    exp_t e;
    int n;
    dif.start = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;

    // reset state
    #12;
    chk("rst_busy", int'(dif.busy), 0);
    chk("rst_done", int'(dif.done), 0);
    chk("rst_q", int'(dif.quotient), 0);
    chk("rst_r", int'(dif.remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    do_op(200, 7);
    do_op(173, 0);
    do_op(225, 15);
    do_op(0, 15);
    do_op(255, 1);
    drain();

    // start during busy is ignored; then start held through done
    do_op(100, 9);
    repeat (3) @(negedge clk);
    dif.start = 1'b1; dif.dividend = 8'd77; dif.divisor = 4'd3;
    repeat (2) @(negedge clk);
    dif.dividend = 8'd60; dif.divisor = 4'd7;
    n = 0;
    while (!dif.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(dif.done), 1);
    @(posedge clk);
    #1;
    e = model(60, 7);
    e.acc = cyc;
    sb.push_back(e);
    dif.start = 1'b0;
    drain();

    // asynchronous reset mid-CALC
    do_op(200, 3);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    last_q = 0;
    last_r = 0;
    #1;
    chk("arst_busy", int'(dif.busy), 0);
    chk("arst_done", int'(dif.done), 0);
    chk("arst_q", int'(dif.quotient), 0);
    chk("arst_r", int'(dif.remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    do_op(50, 5);
    drain();

    // exhaustive sweep, issued back-to-back
    for (int d = 0; d < 256; d++)
      for (int s = 1; s < 16; s++)
        do_op(d, s);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_divider_8by4.md
Name: seq_divider_8by4

Overview:
- Multi-cycle restoring divider; the inverse of the 4-bit combinational multiplier.
- Takes an 8-bit dividend (a multiplier product) and a 4-bit divisor, and returns the quotient and remainder.
- Resolves one quotient bit per clock.
- Used wherever a product must be decomposed back into its factors.
- Start/busy/done handshake toward the issuing logic.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while idle.
- dividend  input  DIVIDEND_W  numerator; sampled on the accept edge.
- divisor  input  DIVISOR_W  denominator; sampled on the accept edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results update.
- quotient  output  DIVIDEND_W  registered quotient.
- remainder  output  DIVISOR_W  registered remainder.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state=IDLE. busy, done, quotient, remainder and the iteration counter all 0.
- Reset mid-operation aborts the operation. No done is produced.
- States:
  - IDLE: start=1 is accepted. On the accept edge, latch the operands, clear the partial remainder (DIVISOR_W+1 bits), set counter=0 and busy=1.
    - If divisor==0, go to ZERO. Otherwise go to CALC.
  - CALC: one iteration per edge:
    - shift the partial remainder left, bringing in the next dividend bit, MSB first;
    - trial-subtract the divisor;
    - if the result is non-negative, keep it and set quotient bit=1; else restore and set bit=0;
    - counter increments.
  - CALC exit: on the edge where counter==DIVIDEND_W-1, write quotient and remainder, set done=1, busy=0, go to IDLE.
  - ZERO: next edge writes quotient=all ones and remainder=dividend[DIVISOR_W-1:0], sets done=1, busy=0, goes to IDLE.
- Latency: done asserts DIVIDEND_W edges after the accept edge (8 by default), or 1 edge for divide-by-zero.
- done is high for exactly one cycle.
- quotient and remainder hold until the next completion. They never change while busy.
- start while busy is ignored; no queuing. The operands may change freely while busy.
- start=1 in the cycle done=1 is accepted (state is IDLE). Back-to-back throughput is one operation per DIVIDEND_W+1 cycles.
- Invariant for divisor!=0: quotient*divisor+remainder == dividend, and remainder < divisor.
- The partial remainder is DIVISOR_W+1 bits wide so the trial subtraction never overflows. The remainder output is its low DIVISOR_W bits.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined: adds output port div_by_zero (1 bit, reset 0).
  - Updated on every done edge: 1 for a ZERO-path completion, 0 for a CALC completion.
  - Holds between completions.
- Undefined: no port. Divide-by-zero is still handled via the ZERO path, with identical quotient and remainder values.

Test Plan:
- dividend=200, divisor=7, start pulse -> done exactly 8 cycles after accept; quotient=28, remainder=4; busy=0 with done.
- Exhaustive sweep of dividend in 0..255 and divisor in 1..15 (every product i*j for i,j in 0..15 included) -> quotient==dividend/divisor and remainder==dividend%divisor. dividend=225, divisor=15 -> quotient=15, remainder=0.
- dividend=173, divisor=0 -> done 1 cycle after accept; quotient=255, remainder=13; div_by_zero=1 when DIV_ZERO_FLAG_EN is defined.
- start reasserted with new operands 3 cycles into an operation on 100/9 -> ignored; result quotient=11, remainder=1. Then start held high through the done cycle -> second operation accepted on that edge.
- rst_n pulsed low asynchronously mid-CALC (between clock edges) -> busy, done, quotient and remainder go to 0 immediately. No done follows. The next start (50/5) -> quotient=10, remainder=0.
- dividend=0, divisor=15 -> quotient=0, remainder=0. dividend=255, divisor=1 -> quotient=255, remainder=0.
